// File: rtl/program_loader_if.sv
//------------------------------------------------------------------------------
// program_loader_if
// Bundles the byte stream from the serial receiver, the program memory write
// port, the CPU fetch address and the loader status flags.
//   slave  : the loader side (consumes rx stream and CPU address, drives the
//            memory port and status)
//   master : the environment side (UART receiver / CPU / memory / bench)
// Signals:
//   rx_data[7:0], rx_valid       received byte and its one-cycle strobe
//   cpu_address_rom[ADDR_W-1:0]  CPU instruction fetch address
//   address_rom[ADDR_W-1:0]      address to program memory
//   data_rom[15:0], wren_rom     program memory write data / write enable
//   cpu_run, busy, done, error   CPU enable and load status
//------------------------------------------------------------------------------
interface program_loader_if #(
   parameter int unsigned ADDR_W = 16
) ();
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic [ADDR_W-1:0] cpu_address_rom;
   logic [ADDR_W-1:0] address_rom;
   logic [15:0]       data_rom;
   logic              wren_rom;
   logic              cpu_run;
   logic              busy;
   logic              done;
   logic              error;

   modport slave (
      input  rx_data, rx_valid, cpu_address_rom,
      output address_rom, data_rom, wren_rom, cpu_run, busy, done, error
   );

   modport master (
      output rx_data, rx_valid, cpu_address_rom,
      input  address_rom, data_rom, wren_rom, cpu_run, busy, done, error
   );
endinterface

// File: rtl/program_loader.sv
//------------------------------------------------------------------------------
// program_loader
// Receives a framed byte stream (MAGIC, LEN_LO, LEN_HI, LEN x {lo,hi}, CHK),
// writes the assembled 16-bit words into program memory from address 0 while
// the CPU is stalled, then hands the memory address bus to the CPU and
// raises cpu_run once the checksum matches.
// Ports:
//   clock    system clock, all logic on posedge
//   reset_n  asynchronous active-low reset
//   bus      program_loader_if.slave (rx stream, memory port, CPU address,
//            status flags)
//------------------------------------------------------------------------------
module program_loader #(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned MAX_WORDS = 1024,
   parameter logic [7:0]  MAGIC     = 8'hA5
) (
   input logic             clock,
   input logic             reset_n,
   program_loader_if.slave bus
);

   typedef enum logic [2:0] {
      S_WAIT_MAGIC = 3'd0,
      S_LEN_LO     = 3'd1,
      S_LEN_HI     = 3'd2,
      S_DATA_LO    = 3'd3,
      S_DATA_HI    = 3'd4,
      S_CHECK      = 3'd5,
      S_DONE       = 3'd6,
      S_ERROR      = 3'd7
   } state_t;

   // 8-bit running checksum, wraps mod 256
   function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] b);
      return acc + b;
   endfunction

   state_t            state_r, state_n;
   logic [15:0]       len_r;
   logic [7:0]        lo_r;
   logic [7:0]        acc_r;
   logic [ADDR_W-1:0] index_r;
   logic [ADDR_W-1:0] load_addr_r;
   logic [15:0]       data_r;
   logic              wren_r;
   logic              busy_r;
   logic              done_r;
   logic              error_r;
   logic              cpu_run_r;

   logic              acc_clr_s;
   logic              acc_add_s;
   logic              len_lo_ld_s;
   logic              len_hi_ld_s;
   logic              lo_ld_s;
   logic              wr_fire_s;
   logic [15:0]       len_s;

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= S_WAIT_MAGIC;
      end else begin
         state_r <= state_n;
      end
   end

   // Next-state and datapath control decode, advancing only on accepted bytes
   always_comb begin
      state_n     = state_r;
      acc_clr_s   = 1'b0;
      acc_add_s   = 1'b0;
      len_lo_ld_s = 1'b0;
      len_hi_ld_s = 1'b0;
      lo_ld_s     = 1'b0;
      wr_fire_s   = 1'b0;
      len_s       = {bus.rx_data, len_r[7:0]};
      if (bus.rx_valid) begin
         case (state_r)
            S_WAIT_MAGIC, S_ERROR: begin
               if (bus.rx_data == MAGIC) begin
                  state_n   = S_LEN_LO;
                  acc_clr_s = 1'b1;
               end else begin
                  state_n = state_r;
               end
            end
            S_LEN_LO: begin
               len_lo_ld_s = 1'b1;
               acc_add_s   = 1'b1;
               state_n     = S_LEN_HI;
            end
            S_LEN_HI: begin
               len_hi_ld_s = 1'b1;
               acc_add_s   = 1'b1;
               if ((len_s == 16'h0000) || (len_s > 16'(MAX_WORDS))) begin
                  state_n = S_ERROR;
               end else begin
                  state_n = S_DATA_LO;
               end
            end
            S_DATA_LO: begin
               lo_ld_s   = 1'b1;
               acc_add_s = 1'b1;
               state_n   = S_DATA_HI;
            end
            S_DATA_HI: begin
               acc_add_s = 1'b1;
               wr_fire_s = 1'b1;
               if ((index_r + ADDR_W'(1)) == ADDR_W'(len_r)) begin
                  state_n = S_CHECK;
               end else begin
                  state_n = S_DATA_LO;
               end
            end
            S_CHECK: begin
               if (bus.rx_data == acc_r) begin
                  state_n = S_DONE;
               end else begin
                  state_n = S_ERROR;
               end
            end
            S_DONE: begin
               state_n = S_DONE;
            end
            default: begin
               state_n = S_WAIT_MAGIC;
            end
         endcase
      end else begin
         state_n = state_r;
      end
   end

   // Datapath, write pipeline and registered status flags
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         len_r       <= 16'h0000;
         lo_r        <= 8'h00;
         acc_r       <= 8'h00;
         index_r     <= '0;
         load_addr_r <= '0;
         data_r      <= 16'h0000;
         wren_r      <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         error_r     <= 1'b0;
         cpu_run_r   <= 1'b0;
      end else begin
         if (acc_clr_s) begin
            acc_r   <= 8'h00;
            index_r <= '0;
         end else begin
            if (acc_add_s) begin
               acc_r <= chk_add(acc_r, bus.rx_data);
            end
            if (wr_fire_s) begin
               index_r <= index_r + ADDR_W'(1);
            end
         end
         if (len_lo_ld_s) begin
            len_r[7:0] <= bus.rx_data;
         end
         if (len_hi_ld_s) begin
            len_r[15:8] <= bus.rx_data;
         end
         if (lo_ld_s) begin
            lo_r <= bus.rx_data;
         end
         // One-deep write slot: a word completes at most every second byte,
         // so the slot is always free again before the next word arrives.
         wren_r      <= wr_fire_s;
         load_addr_r <= wr_fire_s ? index_r : '0;
         data_r      <= wr_fire_s ? {bus.rx_data, lo_r} : 16'h0000;
         busy_r      <= (state_n == S_LEN_LO) || (state_n == S_LEN_HI) ||
                        (state_n == S_DATA_LO) || (state_n == S_DATA_HI) ||
                        (state_n == S_CHECK);
         done_r      <= (state_n == S_DONE);
         error_r     <= (state_n == S_ERROR);
         cpu_run_r   <= (state_n == S_DONE);
      end
   end

   // The CPU owns the address bus combinationally once it is running
   assign bus.address_rom = cpu_run_r ? bus.cpu_address_rom : load_addr_r;
   assign bus.data_rom    = data_r;
   assign bus.wren_rom    = wren_r;
   assign bus.cpu_run     = cpu_run_r;
   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.error       = error_r;

endmodule

// File: tb/tb_program_loader.sv
//------------------------------------------------------------------------------
// tb_program_loader
// Directed bench for program_loader: drives framed byte streams, keeps a
// program memory model fed by the DUT write port and checks outputs against
// hand-computed values.
//------------------------------------------------------------------------------
module tb_program_loader;
   logic clock;
   logic reset_n;

   program_loader_if #(.ADDR_W(16)) bus ();

   program_loader #(.ADDR_W(16), .MAX_WORDS(1024), .MAGIC(8'hA5)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_err = 0;

   // program memory model and write-port monitor, sampled on the falling edge
   logic [15:0] mem [0:2047];
   logic        mem_clr;
   int          wr_count = 0;
   int          overlap_cnt = 0;
   int          wren_run = 0;
   int          wren_run_max = 0;

   always @(negedge clock) begin
      if (mem_clr) begin
         for (int i = 0; i < 2048; i++) mem[i] <= 16'h0000;
      end else if (bus.wren_rom) begin
         mem[bus.address_rom[10:0]] <= bus.data_rom;
         wr_count <= wr_count + 1;
      end
      if (bus.wren_rom && bus.cpu_run) overlap_cnt <= overlap_cnt + 1;
      if (bus.wren_rom) begin
         wren_run = wren_run + 1;
         if (wren_run > wren_run_max) wren_run_max <= wren_run;
      end else begin
         wren_run = 0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // present one byte for exactly one cycle; returns 1 time unit after the accepting edge
   task automatic send(input logic [7:0] b);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(posedge clock);
      #1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
   endtask

   task automatic clear_mem();
      mem_clr = 1'b1;
      @(negedge clock);
      #1;
      mem_clr = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      idle(2);
      reset_n = 1'b1;
      idle(1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_addr"},  bus.address_rom, 32'h0);
      chk({tag, "_data"},  bus.data_rom,    32'h0);
      chk({tag, "_wren"},  bus.wren_rom,    32'h0);
      chk({tag, "_run"},   bus.cpu_run,     32'h0);
      chk({tag, "_busy"},  bus.busy,        32'h0);
      chk({tag, "_done"},  bus.done,        32'h0);
      chk({tag, "_error"}, bus.error,       32'h0);
   endtask

   // gapped / back-to-back frame: 3 words 2211,4433,6655, CHK 68
   task automatic gap_frame(input string tag, input int max_gap);
      logic [7:0] fr [0:8];
      int base;
      fr = '{8'hA5, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      base = wr_count;
      for (int i = 0; i < 9; i++) begin
         send(fr[i]);
         if (max_gap > 0) idle($urandom_range(0, max_gap));
      end
      chk({tag, "_done_before_chk"}, bus.done, 32'h0);
      send(8'h68);
      chk({tag, "_done_at_chk"}, bus.done, 32'h1);
      idle(1);
      chk({tag, "_mem0"}, mem[0], 32'h2211);
      chk({tag, "_mem1"}, mem[1], 32'h4433);
      chk({tag, "_mem2"}, mem[2], 32'h6655);
      chk({tag, "_nwr"}, wr_count - base, 32'd3);
   endtask

   int          base;
   logic [7:0]  acc;
   logic [15:0] w;

   initial begin
      reset_n = 1'b0;
      mem_clr = 1'b0;
      bus.rx_data = 8'h00;
      bus.rx_valid = 1'b0;
      bus.cpu_address_rom = 16'h0003;
      idle(2);
      chk_all_zero("reset");
      reset_n = 1'b1;
      idle(1);
      clear_mem();

      // noise before MAGIC is ignored
      send(8'h00); send(8'hFF); send(8'h5A);
      chk("noise_busy", bus.busy, 32'h0);
      chk("noise_error", bus.error, 32'h0);

      // nominal load
      base = wr_count;
      send(8'hA5);
      chk("nom_busy", bus.busy, 32'h1);
      send(8'h02); send(8'h00); send(8'h01); send(8'h00);
      chk("nom_w0_wren", bus.wren_rom, 32'h1);
      chk("nom_w0_addr", bus.address_rom, 32'h0000);
      chk("nom_w0_data", bus.data_rom, 32'h0001);
      send(8'h0B);
      chk("nom_w0_wren_off", bus.wren_rom, 32'h0);
      send(8'h00);
      chk("nom_w1_wren", bus.wren_rom, 32'h1);
      chk("nom_w1_addr", bus.address_rom, 32'h0001);
      chk("nom_w1_data", bus.data_rom, 32'h000B);
      send(8'h0E);
      chk("nom_done", bus.done, 32'h1);
      chk("nom_run", bus.cpu_run, 32'h1);
      chk("nom_busy_off", bus.busy, 32'h0);
      chk("nom_wren_off", bus.wren_rom, 32'h0);
      chk("nom_addr_cpu", bus.address_rom, 32'h0003);
      bus.cpu_address_rom = 16'h1234;
      #1;
      chk("nom_addr_follow", bus.address_rom, 32'h1234);
      idle(1);
      chk("nom_mem0", mem[0], 32'h0001);
      chk("nom_mem1", mem[1], 32'h000B);
      chk("nom_nwr", wr_count - base, 32'd2);

      // DONE is terminal
      base = wr_count;
      send(8'hA5); send(8'h01); send(8'h00); send(8'h34); send(8'h12); send(8'h47);
      idle(1);
      chk("term_nwr", wr_count - base, 32'd0);
      chk("term_done", bus.done, 32'h1);
      chk("term_busy", bus.busy, 32'h0);

      // bad checksum then recovery
      bus.cpu_address_rom = 16'h0003;
      do_reset();
      clear_mem();
      send(8'hA5); send(8'h01); send(8'h00); send(8'h34); send(8'h12);
      send(8'h00);
      idle(1);
      chk("bad_mem0", mem[0], 32'h1234);
      chk("bad_error", bus.error, 32'h1);
      chk("bad_run", bus.cpu_run, 32'h0);
      chk("bad_done", bus.done, 32'h0);
      chk("bad_busy", bus.busy, 32'h0);
      send(8'h11);
      chk("bad_ignore", bus.error, 32'h1);
      send(8'hA5);
      chk("retry_error_clr", bus.error, 32'h0);
      chk("retry_busy", bus.busy, 32'h1);
      send(8'h01); send(8'h00); send(8'h34); send(8'h12); send(8'h47);
      chk("retry_done", bus.done, 32'h1);

      // length limits
      do_reset();
      base = wr_count;
      send(8'hA5); send(8'h00); send(8'h00);
      chk("len0_error", bus.error, 32'h1);
      send(8'hA5); send(8'h01); send(8'h04);
      chk("len1025_error", bus.error, 32'h1);
      idle(1);
      chk("len_err_nwr", wr_count - base, 32'd0);
      clear_mem();
      send(8'hA5); send(8'h00); send(8'h04);
      chk("len1024_busy", bus.busy, 32'h1);
      chk("len1024_error", bus.error, 32'h0);
      acc = 8'h04;
      for (int i = 0; i < 1024; i++) begin
         w = 16'(i) ^ 16'h5A00;
         send(w[7:0]);
         send(w[15:8]);
         acc = acc + w[7:0] + w[15:8];
      end
      chk("len1024_last_wren", bus.wren_rom, 32'h1);
      chk("len1024_last_addr", bus.address_rom, 32'h03FF);
      chk("len1024_last_data", bus.data_rom, 32'h59FF);
      send(acc);
      chk("len1024_done", bus.done, 32'h1);
      idle(1);
      chk("len1024_mem0", mem[0], 32'h5A00);
      chk("len1024_mem3ff", mem[1023], 32'h59FF);

      // back-to-back vs random gaps
      do_reset();
      clear_mem();
      gap_frame("b2b", 0);
      do_reset();
      clear_mem();
      gap_frame("gap", 5);

      // reset in the middle of word 1
      do_reset();
      clear_mem();
      base = wr_count;
      bus.cpu_address_rom = 16'h0003;
      send(8'hA5); send(8'h02); send(8'h00); send(8'h01); send(8'h00); send(8'h0B);
      reset_n = 1'b0;
      #1;
      chk_all_zero("midrst");
      idle(2);
      chk("midrst_nwr", wr_count - base, 32'd1);
      chk("midrst_mem1", mem[1], 32'h0000);
      reset_n = 1'b1;
      idle(1);
      send(8'hA5); send(8'h02); send(8'h00); send(8'h01); send(8'h00);
      send(8'h0B); send(8'h00); send(8'h0E);
      chk("midrst_reload_done", bus.done, 32'h1);
      idle(1);
      chk("midrst_mem0", mem[0], 32'h0001);
      chk("midrst_mem1_after", mem[1], 32'h000B);

      // write-port invariants over the whole run
      chk("wren_cpu_run_overlap", overlap_cnt, 32'd0);
      chk("wren_max_run", wren_run_max, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
